// File: rtl/pmod_port_arbiter.sv
// pmod_port_arbiter: shares one 4-pin PMOD mux between UART, SPI, GPIO and I2C.
// Round-robin winner selection, settle time after every mux mode change,
// guard time after every grant release, optional forced revocation.
module pmod_port_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned GUARD_CYCLES  = 2,
  parameter int unsigned MAX_HOLD      = 0,
  parameter logic [1:0]  DEFAULT_SEL   = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] revoked
);

  typedef enum logic [1:0] {IDLE, SETTLE, GRANT, GUARD} stateT;

  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [7:0]  GUARD_LOAD  = 8'(GUARD_CYCLES);
  localparam logic [15:0] MAX_HOLD_V  = 16'(MAX_HOLD);

  stateT       state, stateNext;
  logic [3:0]  grantNext;
  logic [1:0]  selNext;
  logic [3:0]  revokedNext;
  logic [1:0]  rrPtr, rrPtrNext;
  logic [7:0]  phaseCnt, phaseCntNext;
  logic [15:0] holdCnt, holdCntNext;
  logic [1:0]  winner;
  logic        othersWaiting;

  // First set request bit scanning upward from the round-robin pointer, wrapping 3->0.
  function automatic logic [1:0] pickWinner(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    pickWinner = ptr;
    found      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && r[idx]) begin
        pickWinner = idx;
        found      = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] oneHot(input logic [1:0] i);
    oneHot = 4'b0001 << i;
  endfunction

  // Hold counter saturates instead of wrapping so a very long grant stays revocable.
  function automatic logic [15:0] satInc16(input logic [15:0] c);
    satInc16 = (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // sel doubles as the registered winner: it always names the current owner outside IDLE.
  assign busy = (state != IDLE);

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    stateNext     = state;
    grantNext     = grant;
    selNext       = sel;
    revokedNext   = '0;
    rrPtrNext     = rrPtr;
    phaseCntNext  = phaseCnt;
    holdCntNext   = holdCnt;
    winner        = pickWinner(req, rrPtr);
    othersWaiting = |(req & ~oneHot(sel));

    case (state)
      IDLE: begin
        if (|req) begin
          selNext = winner;
          if (winner == sel || SETTLE_CYCLES == 0) begin
            grantNext   = oneHot(winner);
            holdCntNext = 16'd1;
            stateNext   = GRANT;
          end else begin
            phaseCntNext = SETTLE_LOAD;
            stateNext    = SETTLE;
          end
        end
      end

      SETTLE: begin
        if (!req[sel]) begin
          // Requester gave up before the mux settled: no grant, pointer untouched.
          phaseCntNext = GUARD_LOAD;
          stateNext    = GUARD;
        end else if (phaseCnt <= 8'd1) begin
          grantNext   = oneHot(sel);
          holdCntNext = 16'd1;
          stateNext   = GRANT;
        end else begin
          phaseCntNext = phaseCnt - 8'd1;
        end
      end

      GRANT: begin
        holdCntNext = satInc16(holdCnt);
        if (!req[sel]) begin
          grantNext    = '0;
          rrPtrNext    = sel + 2'd1;
          phaseCntNext = GUARD_LOAD;
          stateNext    = GUARD;
        end else if (MAX_HOLD != 0 && holdCnt >= MAX_HOLD_V && othersWaiting) begin
          grantNext    = '0;
          revokedNext  = oneHot(sel);
          rrPtrNext    = sel + 2'd1;
          phaseCntNext = GUARD_LOAD;
          stateNext    = GUARD;
        end
      end

      GUARD: begin
        // A zero guard length still spends one cycle here.
        if (phaseCnt <= 8'd1) begin
          stateNext = IDLE;
        end else begin
          phaseCntNext = phaseCnt - 8'd1;
        end
      end

      default: begin
        grantNext = '0;
        stateNext = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts immediately to the idle configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= DEFAULT_SEL;
      revoked  <= '0;
      rrPtr    <= '0;
      phaseCnt <= '0;
      holdCnt  <= '0;
    end else begin
      state    <= stateNext;
      grant    <= grantNext;
      sel      <= selNext;
      revoked  <= revokedNext;
      rrPtr    <= rrPtrNext;
      phaseCnt <= phaseCntNext;
      holdCnt  <= holdCntNext;
    end
  end

endmodule
